arbiter_response_router: RTL and testbench
==========================================

Name: arbiter_response_router

Overview:
- Return-path companion to the fixed-priority request arbiter.
- Records which port won each request that the shared downstream resource accepted, in acceptance order.
- Steers each in-order response from the shared resource back to the port that issued the matching request.
- Sits between the shared responder (e.g. memory/accumulator port) and NUM_PORTS requesters; provides backpressure to the arbiter when tracking capacity is exhausted.

Parameters:
- NUM_PORTS, 2, number of requester ports; must match the arbiter's grant width; >=1.
- DATA_WIDTH, 32, response payload width in bits.
- MAX_OUTSTANDING, 4, depth of the tag FIFO, i.e. maximum accepted-but-unanswered requests; power of two, >=2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_grants  input  NUM_PORTS  one-hot grant vector from the arbiter.
- req_fire  input  1  downstream accepted the granted request this cycle.
- req_allow  output  1  high when a new request may be accepted: count<MAX_OUTSTANDING, or a pop occurs this cycle.
- resp_valid  input  1  shared responder presents a response.
- resp_data  input  DATA_WIDTH  response payload.
- resp_ready  output  1  response consumed by the destination port.
- port_resp_valid  output  NUM_PORTS  per-port response valid.
- port_resp_data  output  NUM_PORTS*DATA_WIDTH  per-port payload; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- port_resp_ready  input  NUM_PORTS  per-port ready.
- outstanding  output  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- err_overflow  output  1  sticky: push attempted while not allowed.
- err_unexpected  output  1  sticky: resp_valid seen while FIFO empty.
- err_grant  output  1  sticky: req_fire with req_grants not exactly one-hot.

Behaviour:
- **Storage.** Tag FIFO of MAX_OUTSTANDING entries; each entry is a port index of width max(1,$clog2(NUM_PORTS)). Read/write pointers wrap modulo MAX_OUTSTANDING. occupancy counter = outstanding.
- **Push.** Push when req_fire=1, req_grants one-hot, and req_allow=1. Stored value = index of the set grant bit. The entry is visible at head the next cycle; no same-cycle bypass.
- **Head routing (combinational).** When FIFO non-empty, head = stored index h.
  - port_resp_valid[h] = resp_valid; all other port_resp_valid bits = 0.
  - resp_ready = port_resp_ready[h].
  - When FIFO empty: port_resp_valid = 0 and resp_ready = 0.
- **Data fanout.** resp_data is broadcast to every port_resp_data slice; only the valid bit qualifies it.
- **Pop.** Pop when resp_valid & resp_ready. Latency from response to port is 0 cycles.
- **Simultaneous push and pop.** Occupancy unchanged; pointers both advance. Allowed when full: req_allow=1 in that cycle.
- **Full without pop.** req_allow=0. A req_fire with one-hot grants is dropped (FIFO unchanged) and sets err_overflow.
- **Grant errors.** req_fire with zero or multiple grant bits: no push, sets err_grant. This applies even when full.
- **Empty.** resp_valid=1 while empty sets err_unexpected; nothing is popped.
- **Sticky errors.** Error flags clear only on rst.
- **Reset.** Pointers=0, outstanding=0, all error flags=0. Consequently port_resp_valid=0, resp_ready=0, req_allow=1 from the cycle after rst is sampled high.
- **Reset mid-operation.** Reset discards all pending tags. Responses arriving afterwards count as unexpected.
- **Ordering.** Responses are strictly in acceptance order; there are no IDs on the response path.
- **NUM_PORTS=1.** Index width is 1; every response is routed to port 0.

Test Plan:
- **Basic routing.** After reset: push grants=2'b10, then 2'b01. Then resp_valid=1 with data 0xA, then 0xB, all ports ready.
  - port_resp_valid=2'b10 with 0xA, then 2'b01 with 0xB.
  - outstanding goes 0→1→2→1→0.
- **Fill and backpressure.** Push 4 tags without responses.
  - outstanding=4, req_allow=0.
  - A 5th req_fire sets err_overflow=1 and outstanding stays 4.
- **Full with same-cycle pop.** At outstanding=4, apply resp_valid & ready together with req_fire grants=2'b01.
  - req_allow=1 and outstanding stays 4.
  - The new tag is routed after the 3 older ones.
- **Destination stall.** Head port 1 with port_resp_ready[1]=0 for 3 cycles, then 1.
  - resp_ready=0 for 3 cycles; the pop happens only on cycle 4.
  - port_resp_valid[0] stays 0 throughout.
- **Error flags.** Inject:
  - resp_valid while empty → err_unexpected=1.
  - req_fire with grants=2'b11 → err_grant=1 and no push.
  - Both flags persist until rst.
- **Wrap and reset.** Run 10 push/pop pairs to wrap the pointers; routing stays correct. Then assert rst with 2 entries pending.
  - Next cycle: outstanding=0, req_allow=1.

Source files
------------

// File: rtl/arbiter_response_router.sv
// Return-path router for the fixed-priority arbiter: remembers which port won each
// accepted request and steers the in-order responses back to that port.
module arbiter_response_router #(
  parameter int NUM_PORTS       = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                req_grants,
  input  logic                                req_fire,
  output logic                                req_allow,
  input  logic                                resp_valid,
  input  logic [DATA_WIDTH-1:0]               resp_data,
  output logic                                resp_ready,
  output logic [NUM_PORTS-1:0]                port_resp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]     port_resp_data,
  input  logic [NUM_PORTS-1:0]                port_resp_ready,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                err_overflow,
  output logic                                err_unexpected,
  output logic                                err_grant
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a response transfers in the cycle resp_valid && resp_ready are both
  // high; resp_ready mirrors the ready of the head port and never waits on
  // resp_valid. A request is recorded when req_fire is high with a one-hot grant
  // and req_allow is high in the same cycle.

  logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             empty;
  logic             full;
  logic [IDX_W-1:0] head;
  logic             grant_onehot;
  logic [IDX_W-1:0] grant_idx;
  logic             push;
  logic             pop;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(MAX_OUTSTANDING));
  assign head  = tag_mem[rd_ptr];

  assign grant_onehot = (req_grants != '0) &&
                        ((req_grants & (req_grants - NUM_PORTS'(1))) == '0);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_grants[i]) grant_idx = IDX_W'(i);
    end
  end

  // Only the head port sees the response; an empty FIFO routes nowhere.
  always_comb begin
    port_resp_valid = '0;
    resp_ready      = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!empty && (head == IDX_W'(i))) begin
        port_resp_valid[i] = resp_valid;
        resp_ready         = port_resp_ready[i];
      end
    end
  end

  assign port_resp_data = {NUM_PORTS{resp_data}};

  assign pop       = resp_valid & resp_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign req_allow = !full || pop;
  assign push      = req_fire & grant_onehot & req_allow;

  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
      err_grant      <= 1'b0;
    end else begin
      if (req_fire && grant_onehot && !req_allow) err_overflow   <= 1'b1;
      if (resp_valid && empty)                    err_unexpected <= 1'b1;
      if (req_fire && !grant_onehot)              err_grant      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_arbiter_response_router.sv
// Directed bench for arbiter_response_router: expected routed responses are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_arbiter_response_router;

  localparam int NP = 2;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int W  = NP + DW;

  logic          clk;
  logic          rst;
  logic [NP-1:0] req_grants;
  logic          req_fire;
  logic          req_allow;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_ready;
  logic [NP-1:0] port_resp_valid;
  logic [NP*DW-1:0] port_resp_data;
  logic [NP-1:0] port_resp_ready;
  logic [$clog2(MO):0] outstanding;
  logic          err_overflow;
  logic          err_unexpected;
  logic          err_grant;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;

  arbiter_response_router #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_grants(req_grants), .req_fire(req_fire), .req_allow(req_allow),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .port_resp_valid(port_resp_valid), .port_resp_data(port_resp_data),
    .port_resp_ready(port_resp_ready), .outstanding(outstanding),
    .err_overflow(err_overflow), .err_unexpected(err_unexpected), .err_grant(err_grant)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic fire, input logic [NP-1:0] g, input logic rv,
                       input logic [DW-1:0] d, input logic [NP-1:0] pr);
    req_fire        = fire;
    req_grants      = g;
    resp_valid      = rv;
    resp_data       = d;
    port_resp_ready = pr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic fire, input logic [NP-1:0] g, input logic rv,
                     input logic [DW-1:0] d, input logic [NP-1:0] pr);
    drive(fire, g, rv, d, pr);
    step();
    drive(1'b0, '0, 1'b0, '0, 2'b11);
  endtask

  task automatic push_req(input logic [NP-1:0] g);
    cyc(1'b1, g, 1'b0, '0, 2'b11);
  endtask

  task automatic respond(input logic [NP-1:0] exp_port, input logic [DW-1:0] d);
    exp_q.push_back({exp_port, d});
    cyc(1'b0, '0, 1'b1, d, 2'b11);
  endtask

  // scoreboard monitor: every completed response transfer is compared
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got port_resp_valid=%b with empty queue", port_resp_valid);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("route_mask", 64'(port_resp_valid), 64'(e[W-1:DW]));
        for (int p = 0; p < NP; p++) begin
          if (e[DW+p]) check("route_data", 64'(port_resp_data[p*DW +: DW]), 64'(e[DW-1:0]));
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, '0, 1'b0, '0, 2'b11);
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_req_allow", 64'(req_allow), 64'd1);
    check("rst_resp_ready", 64'(resp_ready), 64'd0);
    check("rst_port_valid", 64'(port_resp_valid), 64'd0);
    check("rst_errs", 64'({err_overflow, err_unexpected, err_grant}), 64'd0);

    // basic routing
    push_req(2'b10);
    check("basic_out1", 64'(outstanding), 64'd1);
    push_req(2'b01);
    check("basic_out2", 64'(outstanding), 64'd2);
    respond(2'b10, 32'hA);
    check("basic_out3", 64'(outstanding), 64'd1);
    respond(2'b01, 32'hB);
    check("basic_out4", 64'(outstanding), 64'd0);

    // fill and backpressure
    push_req(2'b01);
    push_req(2'b10);
    push_req(2'b10);
    push_req(2'b01);
    check("fill_out", 64'(outstanding), 64'd4);
    check("fill_allow", 64'(req_allow), 64'd0);
    push_req(2'b10);
    check("ovf_flag", 64'(err_overflow), 64'd1);
    check("ovf_out", 64'(outstanding), 64'd4);

    // full with same-cycle pop and push
    exp_q.push_back({2'b01, 32'h11});
    drive(1'b1, 2'b01, 1'b1, 32'h11, 2'b11);
    #1;
    check("full_pop_allow", 64'(req_allow), 64'd1);
    step();
    drive(1'b0, '0, 1'b0, '0, 2'b11);
    check("full_pop_out", 64'(outstanding), 64'd4);
    respond(2'b10, 32'h21);
    respond(2'b10, 32'h22);
    respond(2'b01, 32'h23);
    respond(2'b01, 32'h24);
    check("drain_out", 64'(outstanding), 64'd0);

    // destination stall on port 1
    push_req(2'b10);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, 1'b1, 32'h55, 2'b01);
      #1;
      check("stall_ready", 64'(resp_ready), 64'd0);
      check("stall_valid", 64'(port_resp_valid), 64'(2'b10));
      step();
      check("stall_out", 64'(outstanding), 64'd1);
    end
    respond(2'b10, 32'h55);
    check("stall_done_out", 64'(outstanding), 64'd0);

    // error flags
    cyc(1'b0, '0, 1'b1, 32'h77, 2'b11);
    check("unexp_flag", 64'(err_unexpected), 64'd1);
    cyc(1'b1, 2'b11, 1'b0, '0, 2'b11);
    check("grant_flag", 64'(err_grant), 64'd1);
    check("grant_nopush", 64'(outstanding), 64'd0);
    cyc(1'b1, 2'b00, 1'b0, '0, 2'b11);
    check("grant_zero_nopush", 64'(outstanding), 64'd0);
    step();
    step();
    check("sticky_errs", 64'({err_overflow, err_unexpected, err_grant}), 64'b111);

    // pointer wrap
    for (int k = 0; k < 10; k++) begin
      logic [NP-1:0] g;
      g = (k % 2 == 1) ? 2'b10 : 2'b01;
      push_req(g);
      respond(g, 32'h100 + 32'(k));
    end
    check("wrap_out", 64'(outstanding), 64'd0);

    // reset with entries pending
    push_req(2'b01);
    push_req(2'b10);
    check("pend_out", 64'(outstanding), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_out", 64'(outstanding), 64'd0);
    check("rst2_allow", 64'(req_allow), 64'd1);
    check("rst2_port_valid", 64'(port_resp_valid), 64'd0);
    check("rst2_errs", 64'({err_overflow, err_unexpected, err_grant}), 64'd0);
    cyc(1'b0, '0, 1'b1, 32'h99, 2'b11);
    check("post_rst_unexp", 64'(err_unexpected), 64'd1);

    step();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
